csr_reg_bank: RTL and testbench

- Leaf CSR target on the slave side of a csr_if channel. Signals are flattened to ports and connect one-to-one to the interface's slave modport.
- Holds a small bank of privilege-checked read/write configuration registers plus one sticky clear-on-read status register fed by hardware.
- Returns registered responses that honour req/rsp valid-ready backpressure.
- Drives decoded configuration values and per-register write pulses to the owning unit.

---
 rtl/csr_reg_bank.sv | 146 ++++++++++++++
 tb/tb_csr_reg_bank.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/csr_reg_bank.sv
// rtl/csr_reg_bank.sv - privilege-checked CSR bank with clear-on-read status register
module csr_reg_bank #(
    parameter int                  ADDR_W      = 32,
    parameter int                  DATA_W      = 32,
    parameter int                  PRIV_W      = 2,
    parameter int                  NUM_REGS    = 4,
    parameter logic [ADDR_W-1:0]   BASE_ADDR   = 32'h0000_0100,
    parameter int                  STATUS_IDX  = NUM_REGS - 1,
    parameter int                  RD_PRIV_MIN = 0,
    parameter int                  WR_PRIV_MIN = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    input  logic [DATA_W/8-1:0]        req_wstrb,
    input  logic [PRIV_W-1:0]          req_priv,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_fault,
    output logic                       rsp_side_effect,
    input  logic [DATA_W-1:0]          hw_status_set,
    output logic [NUM_REGS*DATA_W-1:0] cfg_q,
    output logic [NUM_REGS-1:0]        cfg_wr_pulse
);

    localparam int BYTES = DATA_W / 8;

    logic [DATA_W-1:0]   r_regs [NUM_REGS];

    logic                w_acc;
    logic [ADDR_W-1:0]   w_off;
    logic [ADDR_W-1:0]   w_idx;
    logic                w_misalign;
    logic                w_idx_bad;
    logic                w_is_status;
    int                  w_priv;
    logic                w_priv_bad;
    logic                w_fault;
    logic                w_rd_hit;
    logic                w_wr_hit;
    logic                w_status_clr;
    logic [DATA_W-1:0]   w_rd_val;
    logic [DATA_W-1:0]   w_wr_val;
    logic [NUM_REGS-1:0] w_wr_sel;

    // A new request can enter whenever the single response slot is empty or draining.
    assign req_ready = !rsp_valid || rsp_ready;
    assign w_acc     = req_valid && req_ready;

    // Address decode; the subtraction wraps so addresses below the base land far out of range.
    assign w_off       = req_addr - BASE_ADDR;
    assign w_idx       = w_off / ADDR_W'(BYTES);
    assign w_misalign  = (w_off % ADDR_W'(BYTES)) != '0;
    assign w_idx_bad   = w_idx >= ADDR_W'(NUM_REGS);
    assign w_is_status = w_idx == ADDR_W'(STATUS_IDX);
    assign w_priv      = int'(req_priv);
    assign w_priv_bad  = req_write ? (w_priv < WR_PRIV_MIN) : (w_priv < RD_PRIV_MIN);
    assign w_fault     = w_misalign || w_idx_bad || w_priv_bad || (req_write && w_is_status);

    assign w_rd_hit     = w_acc && !req_write && !w_fault;
    assign w_wr_hit     = w_acc &&  req_write && !w_fault;
    assign w_status_clr = w_rd_hit && w_is_status;

    // Select the addressed register and build its byte-merged post-write value.
    always_comb begin
        w_rd_val = '0;
        w_wr_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_idx == ADDR_W'(i)) begin
                w_rd_val    = r_regs[i];
                w_wr_sel[i] = w_wr_hit;
            end
        end
        w_wr_val = w_rd_val;
        for (int b = 0; b < BYTES; b++) begin
            if (req_wstrb[b]) begin
                w_wr_val[b*8 +: 8] = req_wdata[b*8 +: 8];
            end
        end
    end

    // Register storage: config regs take byte-lane writes, the status reg accumulates hw set
    // pulses and is cleared by an accepted read while same-cycle set bits still land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i == STATUS_IDX) begin
                    r_regs[i] <= (r_regs[i] & ~{DATA_W{w_status_clr}}) | hw_status_set;
                end else if (w_wr_sel[i]) begin
                    r_regs[i] <= w_wr_val;
                end
            end
        end
    end

    // Response slot: loads on accept, holds while stalled, empties when drained with no new accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_fault       <= 1'b0;
            rsp_side_effect <= 1'b0;
        end else if (w_acc) begin
            rsp_valid       <= 1'b1;
            rsp_fault       <= w_fault;
            if (w_fault) begin
                rsp_rdata       <= '0;
                rsp_side_effect <= 1'b0;
            end else if (req_write) begin
                rsp_rdata       <= w_wr_val;
                rsp_side_effect <= |req_wstrb;
            end else begin
                rsp_rdata       <= w_rd_val;
                rsp_side_effect <= w_is_status;
            end
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // One-cycle write notification to the owning unit, even for an all-zero strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_wr_pulse <= '0;
        end else begin
            cfg_wr_pulse <= w_wr_sel;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_cfg
            assign cfg_q[g*DATA_W +: DATA_W] = r_regs[g];
        end
    endgenerate

endmodule

// File: tb/tb_csr_reg_bank.sv
// tb/tb_csr_reg_bank.sv - directed self-checking bench for csr_reg_bank
module tb_csr_reg_bank;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [31:0]  req_addr;
    logic [31:0]  req_wdata;
    logic [3:0]   req_wstrb;
    logic [1:0]   req_priv;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [31:0]  rsp_rdata;
    logic         rsp_fault;
    logic         rsp_side_effect;
    logic [31:0]  hw_status_set;
    logic [127:0] cfg_q;
    logic [3:0]   cfg_wr_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    csr_reg_bank dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_wstrb       (req_wstrb),
        .req_priv        (req_priv),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rdata       (rsp_rdata),
        .rsp_fault       (rsp_fault),
        .rsp_side_effect (rsp_side_effect),
        .hw_status_set   (hw_status_set),
        .cfg_q           (cfg_q),
        .cfg_wr_pulse    (cfg_wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One request with rsp_ready high; response fields are checked one cycle after accept.
    task automatic xact(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, input logic [1:0] p,
                        input logic [31:0] hw,
                        input logic [31:0] exp_data, input logic exp_fault,
                        input logic exp_side, input logic [3:0] exp_pulse);
        @(negedge clk);
        req_valid     = 1'b1;
        req_write     = w;
        req_addr      = a;
        req_wdata     = d;
        req_wstrb     = s;
        req_priv      = p;
        hw_status_set = hw;
        chk({tag, ".req_ready"}, 128'(req_ready), 128'(1'b1));
        @(negedge clk);
        req_valid     = 1'b0;
        hw_status_set = '0;
        chk({tag, ".rsp_valid"}, 128'(rsp_valid), 128'(1'b1));
        chk({tag, ".rdata"}, 128'(rsp_rdata), 128'(exp_data));
        chk({tag, ".fault"}, 128'(rsp_fault), 128'(exp_fault));
        chk({tag, ".side"}, 128'(rsp_side_effect), 128'(exp_side));
        chk({tag, ".pulse"}, 128'(cfg_wr_pulse), 128'(exp_pulse));
    endtask

    task automatic hw_pulse(input logic [31:0] v);
        @(negedge clk);
        hw_status_set = v;
        @(negedge clk);
        hw_status_set = '0;
    endtask

    initial begin
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_write     = 1'b0;
        req_addr      = '0;
        req_wdata     = '0;
        req_wstrb     = '0;
        req_priv      = '0;
        rsp_ready     = 1'b1;
        hw_status_set = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.rsp_valid", 128'(rsp_valid), 128'(1'b0));
        chk("rst.cfg_q", cfg_q, 128'h0);
        chk("rst.pulse", 128'(cfg_wr_pulse), 128'(4'b0000));
        chk("rst.req_ready", 128'(req_ready), 128'(1'b1));
        rst_n = 1'b1;

        // Full and partial writes
        xact("wr1", 1'b1, 32'h104, 32'hDEAD_BEEF, 4'hF, 2'd2, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 4'b0010);
        chk("wr1.cfg_q1", 128'(cfg_q[63:32]), 128'(32'hDEAD_BEEF));
        @(negedge clk);
        chk("wr1.pulse_gone", 128'(cfg_wr_pulse), 128'(4'b0000));
        xact("wr1p", 1'b1, 32'h104, 32'h1122_3344, 4'b0101, 2'd3, 32'h0, 32'hDE22_BE44, 1'b0, 1'b1, 4'b0010);
        xact("rd1", 1'b0, 32'h104, 32'h0, 4'h0, 2'd0, 32'h0, 32'hDE22_BE44, 1'b0, 1'b0, 4'b0000);
        xact("wr2", 1'b1, 32'h108, 32'hA5A5_0F0F, 4'hF, 2'd2, 32'h0, 32'hA5A5_0F0F, 1'b0, 1'b1, 4'b0100);
        xact("wr0s0", 1'b1, 32'h100, 32'hFFFF_FFFF, 4'h0, 2'd2, 32'h0, 32'h0, 1'b0, 1'b0, 4'b0001);

        // Faults
        xact("f_priv", 1'b1, 32'h100, 32'hFFFF_FFFF, 4'hF, 2'd1, 32'h0, 32'h0, 1'b1, 1'b0, 4'b0000);
        chk("f_priv.cfg_q0", 128'(cfg_q[31:0]), 128'(32'h0));
        xact("f_align", 1'b0, 32'h102, 32'h0, 4'h0, 2'd3, 32'h0, 32'h0, 1'b1, 1'b0, 4'b0000);
        xact("f_high", 1'b0, 32'h110, 32'h0, 4'h0, 2'd3, 32'h0, 32'h0, 1'b1, 1'b0, 4'b0000);
        xact("f_low", 1'b0, 32'h0FC, 32'h0, 4'h0, 2'd3, 32'h0, 32'h0, 1'b1, 1'b0, 4'b0000);
        xact("f_stw", 1'b1, 32'h10C, 32'hFFFF_FFFF, 4'hF, 2'd3, 32'h0, 32'h0, 1'b1, 1'b0, 4'b0000);

        // Status register: sticky, clear on read, same-cycle set survives
        hw_pulse(32'h5);
        xact("st_rd1", 1'b0, 32'h10C, 32'h0, 4'h0, 2'd0, 32'h0, 32'h5, 1'b0, 1'b1, 4'b0000);
        xact("st_rd2", 1'b0, 32'h10C, 32'h0, 4'h0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 4'b0000);
        hw_pulse(32'h1);
        xact("st_race", 1'b0, 32'h10C, 32'h0, 4'h0, 2'd0, 32'h8, 32'h1, 1'b0, 1'b1, 4'b0000);
        xact("st_after", 1'b0, 32'h10C, 32'h0, 4'h0, 2'd0, 32'h0, 32'h8, 1'b0, 1'b1, 4'b0000);

        // Backpressure: A = read reg1, B = write reg0 held off while the response is stalled
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h104;
        req_priv  = 2'd0;
        @(negedge clk);
        req_write = 1'b1;
        req_addr  = 32'h100;
        req_wdata = 32'h1234_5678;
        req_wstrb = 4'hF;
        req_priv  = 2'd2;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            chk($sformatf("bp%0d.req_ready", c), 128'(req_ready), 128'(1'b0));
            chk($sformatf("bp%0d.rsp_valid", c), 128'(rsp_valid), 128'(1'b1));
            chk($sformatf("bp%0d.rdata", c), 128'(rsp_rdata), 128'(32'hDE22_BE44));
            chk($sformatf("bp%0d.cfg_q0", c), 128'(cfg_q[31:0]), 128'(32'h0));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("bpB.rsp_valid", 128'(rsp_valid), 128'(1'b1));
        chk("bpB.rdata", 128'(rsp_rdata), 128'(32'h1234_5678));
        chk("bpB.side", 128'(rsp_side_effect), 128'(1'b1));
        chk("bpB.cfg_q0", 128'(cfg_q[31:0]), 128'(32'h1234_5678));
        @(negedge clk);
        chk("bp.drained", 128'(rsp_valid), 128'(1'b0));

        // Streaming reads of regs 0..3, then reset mid-stream
        req_write = 1'b0;
        req_priv  = 2'd0;
        for (int i = 0; i < 5; i++) begin
            logic [31:0] exp_rd [4];
            exp_rd[0] = 32'h1234_5678;
            exp_rd[1] = 32'hDE22_BE44;
            exp_rd[2] = 32'hA5A5_0F0F;
            exp_rd[3] = 32'h0;
            if (i > 0) begin
                chk($sformatf("str%0d.rsp_valid", i - 1), 128'(rsp_valid), 128'(1'b1));
                chk($sformatf("str%0d.rdata", i - 1), 128'(rsp_rdata), 128'(exp_rd[i-1]));
            end
            req_valid = 1'b1;
            req_addr  = 32'h100 + 32'(i % 4) * 32'd4;
            @(negedge clk);
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid.rsp_valid", 128'(rsp_valid), 128'(1'b0));
        chk("rst_mid.cfg_q", cfg_q, 128'h0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            xact($sformatf("post%0d", i), 1'b0, 32'h100 + 32'(i) * 32'd4, 32'h0, 4'h0, 2'd0,
                 32'h0, 32'h0, 1'b0, (i == 3), 4'b0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
